// File: rtl/sec_tick_counter.sv
// Seconds stage of the clock datapath: 1 Hz prescaler, 0..59 seconds counter,
// wrap carry to the minutes stage, manual set-mode adjust and a 1 Hz blink.
module sec_tick_counter #(
    parameter int CLK_HZ = 50_000_000,
    parameter int PW     = $clog2(CLK_HZ)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ctrl_set,
    input  logic       inc,
    input  logic       dec,
    input  logic       clr,
    output logic [5:0] sec_count,
    output logic       tick,
    output logic       carry_out,
    output logic       blink
);

    localparam logic [PW-1:0] TERM = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] HALF = PW'(CLK_HZ / 2);

    logic [PW-1:0] cnt_q, cnt_d;
    logic [5:0]    sec_q, sec_d;
    logic          tick_q, tick_d;
    logic          carry_q, carry_d;
    logic          blink_q, blink_d;

    // Out-of-range values (60..63) fold back into 0..59 on the next step.
    function automatic logic [5:0] sec_inc(input logic [5:0] s);
        return (s >= 6'd59) ? 6'd0 : s + 6'd1;
    endfunction

    function automatic logic [5:0] sec_dec(input logic [5:0] s);
        return (s == 6'd0 || s > 6'd59) ? 6'd59 : s - 6'd1;
    endfunction

    always_comb begin
        cnt_d   = cnt_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        carry_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
            sec_d = '0;
        end else if (ctrl_set) begin
            // Holding the prescaler at 0 resynchronises the second to set release.
            cnt_d = '0;
            if (inc) begin
                sec_d = sec_inc(sec_q);
            end else if (dec) begin
                sec_d = sec_dec(sec_q);
            end
        end else if (cnt_q == TERM) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            carry_d = (sec_q == 6'd59);
            sec_d   = sec_inc(sec_q);
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
        blink_d = (cnt_d < HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            blink_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            carry_q <= carry_d;
            blink_q <= blink_d;
        end
    end

    assign sec_count = sec_q;
    assign tick      = tick_q;
    assign carry_out = carry_q;
    assign blink     = blink_q;

endmodule
